fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end; the producer side of the next-PC path. Holds the fetch PC,
//  issues one word request at a time to instruction memory, and presents {instruction, PC+4}
//  to decode. Accepts redirects from the jump/branch next-PC logic and discards stale fetches.
//  Sits between imem and the decode stage. Decode in turn feeds the jump/branch logic.
// PARAMETERS
//  RESET_PC   32'h0000_0000   fetch address after reset (word aligned)
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request this cycle
//  imem_req_addr   out  32  fetch address, bits[1:0] always 00
//  imem_rsp_valid  in   1   response word valid; in order, >=1 cycle after accept, never stalls
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   take redirect_pc as the next fetch address
//  redirect_pc     in   32  jump/branch target; bits[1:0] ignored, forced to 00
//  if_valid        out  1   instruction available to decode
//  if_ready        in   1   decode accepts this cycle
//  if_instr        out  32  fetched instruction
//  if_pc4          out  32  fetch address + 4, mod 2^32
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset values: pc=RESET_PC, state=REQ, imem_req_valid=0 while reset is asserted,
//    if_valid=0, if_instr=0, if_pc4=0.
//  - Only one request is outstanding at a time.
//  - Request handshake: imem_req_valid && imem_req_ready. Output handshake: if_valid && if_ready.
//  - States:
//    - REQ: imem_req_valid=1, addr=pc. On accept, latch pc4=pc+4 and go to WAIT.
//    - WAIT: on imem_rsp_valid, register if_instr=data and if_pc4=pc4, and set if_valid=1
//      next cycle. Then go to HOLD.
//    - HOLD: if_valid=1 and outputs stay stable. On the output handshake, set if_valid=0,
//      set pc=pc4 and go to REQ.
//    - DROP: wait for imem_rsp_valid, discard the word and go to REQ.
//  - imem_rsp_valid is ignored in REQ and HOLD (covers a stale response after reset).
//  - Latency: request accepted in cycle N, response in cycle M>N, if_valid=1 in cycle M+1.
//    With a 1-cycle imem, steady-state throughput is 1 instruction per 3 cycles.
//  - Redirect has priority over all other events. pc<=redirect_pc&~3 and if_valid<=0.
//    Next state:
//    - REQ with request accepted in the same cycle: DROP.
//    - REQ without accept: REQ (new address, no request issued with the old pc).
//    - WAIT without rsp_valid: DROP.
//    - WAIT with rsp_valid: discard the word, go to REQ.
//    - HOLD: REQ. An output handshake in the same cycle still counts as delivered.
//    - DROP: stay in DROP with the updated pc.
//  - Wrap: pc=32'hFFFF_FFFC gives if_pc4=32'h0000_0000, and the next sequential fetch is 0.
//  - Reset asserted mid-operation returns everything to reset values immediately.
//    Any in-flight imem response is then ignored.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//    - RESET_PC default
//    - INSTR_W=32, ADDR_W=32
//    - fetch_state_t enum {REQ, WAIT, HOLD, DROP}, 2-bit encoding
//  - Sub-module fetch_pc_reg: pc register with async reset, +4 incrementer, redirect
//    load and alignment masking. The FSM and output registers live in fetch_unit.
// TESTING
//  1. RESET_PC=32'h0040_0000; release reset -> req_addr=0x0040_0000 with req_valid=1 on the
//     next edge; if_valid=0.
//  2. Always-ready imem with 1-cycle rsp and if_ready=1 -> req addrs 0x400000, 0x400004,
//     0x400008. if_pc4 = addr+4 and if_instr = the data returned for each request.
//  3. Hold if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc4 stay stable;
//     req_valid=0 throughout. Then if_ready=1 -> exactly one transfer.
//  4. Redirect to 0x0000_1000 in WAIT with rsp 2 cycles later -> old word never appears on
//     if_valid; next request addr=0x1000.
//  5. Redirect to 0xFFFF_FFFE -> req addr 0xFFFF_FFFC and if_pc4=0x0000_0000; next req addr=0x0.
//  6. Assert reset in WAIT, release, then drive a stale rsp_valid in REQ -> it is ignored and
//     req_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, default reset PC, and the fetch FSM state type.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    // Instruction fetch is word granular; low address bits are always dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: async reset to RESET_PC, redirect load with word alignment,
// sequential +4 advance, and the combinational pc+4 used for the return address.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Redirect wins over a same-cycle sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
        end else if (advance) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= align_word(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + ADDR_W'(4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request at a time, delivers
// {instruction, pc+4} to decode, and squashes stale fetches on redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc4
);

    // Handshakes: a transfer occurs on a cycle where valid && ready; a raised valid
    // keeps its payload stable until that transfer, or until a redirect or reset.

    fetch_state_t       state_q, state_d;
    logic               req_valid_q, req_valid_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc4_q, if_pc4_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;

    logic               pc_advance;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               req_fire;
    logic               out_fire;

    assign req_fire = req_valid_q && imem_req_ready;
    assign out_fire = if_valid_q && if_ready;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (pc_advance),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        pc4_d      = pc4_q;
        pc_advance = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    // An accepted request still owes us a response that must be dropped.
                    state_d = req_fire ? S_DROP : S_REQ;
                end else if (req_fire) begin
                    pc4_d   = pc_plus4;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    if_instr_d = imem_rsp_data;
                    if_pc4_d   = pc4_q;
                    if_valid_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (out_fire) begin
                    if_valid_d = 1'b0;
                    pc_advance = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (!redirect_valid && imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            if_valid_d = 1'b0;
        end

        // Request valid is registered so it is low during reset and rises one edge later.
        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc4_q    <= '0;
            pc4_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc4_q    <= if_pc4_d;
            pc4_q       <= pc4_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc4         = if_pc4_q;

endmodule
